// File: rtl/neopixel_frame_sequencer.sv
// Frame scheduler for a NeoPixel strand controller: shadows host colour writes,
// snapshots them per frame and streams every colour load followed by one send_it.
module neopixel_frame_sequencer #(
    parameter int NUM_PIXELS     = 5,
    parameter int REFRESH_CYCLES = 0,
    parameter int BUSY_TIMEOUT   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [2:0] wr_pixel,
    input  logic [1:0] wr_color,
    input  logic [7:0] wr_level,
    input  logic       commit,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic       load_color,
    output logic [2:0] pixel_index,
    output logic [1:0] color_index,
    output logic [7:0] color_level,
    output logic       send_it,
    output logic       busy,
    output logic       frame_done,
    output logic       pending,
    output logic       wr_err
);

    localparam bit          REFRESH_EN   = (REFRESH_CYCLES > 0);
    localparam logic [31:0] REFRESH_LAST = (REFRESH_CYCLES > 0) ? 32'(REFRESH_CYCLES - 1) : 32'd0;
    localparam logic [31:0] TIMEOUT_LAST = (BUSY_TIMEOUT > 0) ? 32'(BUSY_TIMEOUT - 1) : 32'd0;
    localparam logic [2:0]  LAST_PIXEL   = 3'(NUM_PIXELS - 1);
    localparam logic [3:0]  PIXEL_LIMIT  = 4'(NUM_PIXELS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND      = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_shadow   [8][3];
    logic [7:0]  r_snapshot [8][3];
    logic [2:0]  r_ptr_pixel;
    logic [1:0]  r_ptr_color;
    logic [31:0] r_refresh_cnt;
    logic [31:0] r_timeout_cnt;
    logic        r_pending;
    logic        r_frame_done;
    logic        r_wr_err;

    logic        w_wr_valid;
    logic        w_refresh_hit;
    logic        w_start;
    logic        w_load_accept;
    logic        w_last_load;
    logic        w_load_color;
    logic [2:0]  w_pixel_index;
    logic [1:0]  w_color_index;
    logic [7:0]  w_color_level;
    logic        w_send_it;
    logic        w_busy;

    assign w_wr_valid    = wr_en && ({1'b0, wr_pixel} < PIXEL_LIMIT) && (wr_color != 2'b11);
    assign w_refresh_hit = REFRESH_EN && (r_refresh_cnt == REFRESH_LAST);
    assign w_start       = (r_state == S_IDLE) && (w_next_state == S_LOAD);
    assign w_load_accept = (r_state == S_LOAD) && ready_to_load;
    assign w_last_load   = (r_ptr_pixel == LAST_PIXEL) && (r_ptr_color == 2'd2);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (commit || r_pending || w_refresh_hit) w_next_state = S_LOAD;
                else                                      w_next_state = S_IDLE;
            end
            S_LOAD: begin
                if (w_load_accept && w_last_load) w_next_state = S_SEND;
                else                              w_next_state = S_LOAD;
            end
            S_SEND: begin
                if (ready_to_send) w_next_state = S_WAIT_BUSY;
                else               w_next_state = S_SEND;
            end
            S_WAIT_BUSY: begin
                // A strand that never reports busy must not stall the scheduler forever
                if (!ready_to_load || (r_timeout_cnt >= TIMEOUT_LAST)) w_next_state = S_WAIT_DONE;
                else                                                   w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_DONE: begin
                if (ready_to_load) w_next_state = S_IDLE;
                else               w_next_state = S_WAIT_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode; load fields stay zero outside LOAD
    always_comb begin
        w_load_color  = 1'b0;
        w_pixel_index = 3'd0;
        w_color_index = 2'd0;
        w_color_level = 8'h00;
        w_send_it     = 1'b0;
        w_busy        = 1'b1;
        case (r_state)
            S_IDLE: w_busy = 1'b0;
            S_LOAD: begin
                w_load_color  = 1'b1;
                w_pixel_index = r_ptr_pixel;
                w_color_index = r_ptr_color;
                w_color_level = r_snapshot[r_ptr_pixel][r_ptr_color];
            end
            S_SEND:      w_send_it = 1'b1;
            S_WAIT_BUSY: w_busy    = 1'b1;
            S_WAIT_DONE: w_busy    = 1'b1;
            default:     w_busy    = 1'b0;
        endcase
    end

    // Shadow writes and frame snapshot (snapshot sees the pre-write shadow)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow   <= '{default: '{default: 8'h00}};
            r_snapshot <= '{default: '{default: 8'h00}};
        end else begin
            if (w_wr_valid) begin
                r_shadow[wr_pixel][wr_color] <= wr_level;
            end
            if (w_start) begin
                r_snapshot <= r_shadow;
            end
        end
    end

    // Load pointer, counters and status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr_pixel   <= 3'd0;
            r_ptr_color   <= 2'd0;
            r_refresh_cnt <= 32'd0;
            r_timeout_cnt <= 32'd0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_wr_err      <= 1'b0;
        end else begin
            if (r_state != S_LOAD) begin
                r_ptr_pixel <= 3'd0;
                r_ptr_color <= 2'd0;
            end else if (w_load_accept) begin
                if (r_ptr_color == 2'd2) begin
                    r_ptr_color <= 2'd0;
                    r_ptr_pixel <= r_ptr_pixel + 3'd1;
                end else begin
                    r_ptr_color <= r_ptr_color + 2'd1;
                end
            end

            if (REFRESH_EN && (r_state == S_IDLE) && (w_next_state == S_IDLE)) begin
                r_refresh_cnt <= r_refresh_cnt + 32'd1;
            end else begin
                r_refresh_cnt <= 32'd0;
            end

            if ((r_state == S_WAIT_BUSY) && (w_next_state == S_WAIT_BUSY)) begin
                r_timeout_cnt <= r_timeout_cnt + 32'd1;
            end else begin
                r_timeout_cnt <= 32'd0;
            end

            if (w_start) begin
                r_pending <= 1'b0;
            end else if (commit && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            r_frame_done <= (r_state == S_WAIT_DONE) && (w_next_state == S_IDLE);
            r_wr_err     <= wr_en && !w_wr_valid;
        end
    end

    assign load_color  = w_load_color;
    assign pixel_index = w_pixel_index;
    assign color_index = w_color_index;
    assign color_level = w_color_level;
    assign send_it     = w_send_it;
    assign busy        = w_busy;
    assign frame_done  = r_frame_done;
    assign pending     = r_pending;
    assign wr_err      = r_wr_err;

endmodule

// File: doc/neopixel_frame_sequencer.md
Name: neopixel_frame_sequencer

Overview:
- Host-side scheduler for NeoPixelStrandController.
- Host writes per-pixel R/B/G levels into a shadow buffer. On commit (or an auto-refresh tick) the block snapshots the buffer and streams every colour load into the strand controller via load_color/ready_to_load, then issues one send_it pulse.
- Sits between host/register logic and the strand controller; the only master of the strand controller's load/send interface.

Parameters:
- NUM_PIXELS, 5, pixels on the strand (1..8; pixel_index is 3 bits).
- REFRESH_CYCLES, 0, idle cycles before an automatic re-send of the last snapshot; 0 disables auto-refresh.
- BUSY_TIMEOUT, 8, max cycles to wait for ready_to_load to drop after send_it before proceeding.

Ports:
- clock  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  host write strobe.
- wr_pixel  in  3  pixel to write.
- wr_color  in  2  00=Red, 01=Blue, 10=Green, 11=invalid.
- wr_level  in  8  colour level.
- commit  in  1  request a frame transmission.
- ready_to_load  in  1  strand controller accepts a colour load this cycle.
- ready_to_send  in  1  strand controller accepts send_it this cycle.
- load_color  out  1  colour load request to strand controller.
- pixel_index  out  3  pixel for current load.
- color_index  out  2  colour for current load.
- color_level  out  8  level for current load.
- send_it  out  1  one-cycle send request.
- busy  out  1  frame in progress (any state but IDLE).
- frame_done  out  1  one-cycle pulse when a frame completes.
- pending  out  1  a commit is queued behind the active frame.
- wr_err  out  1  one-cycle pulse: previous-cycle write rejected.

Behaviour:
- Reset (async) values:
  - All outputs 0; state IDLE.
  - Shadow and snapshot buffers cleared to 0; refresh counter 0; pending 0.
- Shadow buffer writes:
  - Buffer is NUM_PIXELS x 3 bytes.
  - A write with wr_en=1, wr_pixel<NUM_PIXELS and wr_color!=11 updates the entry at the posedge. Writes are accepted in any state.
  - An invalid write is ignored; wr_err=1 on the following cycle.
- Snapshot:
  - On the IDLE->LOAD transition the whole shadow is copied into the snapshot. Later writes never affect the frame in flight.
  - A write in the same cycle as the transition is NOT included in that snapshot.
- States: IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Goes to LOAD when commit=1, or when pending=1, or when the refresh counter reaches REFRESH_CYCLES-1 with REFRESH_CYCLES!=0.
  - The counter increments only in IDLE, is cleared on leaving IDLE, and is held at 0 when REFRESH_CYCLES=0.
- LOAD:
  - Holds load_color=1, driving the snapshot entry for load pointer (p,c).
  - Order: p=0..NUM_PIXELS-1 outer; c=00,01,10 inner.
  - A load completes on a posedge with load_color=1 and ready_to_load=1; the pointer then advances. With ready_to_load=0 the outputs are held stable.
  - After the 3*NUM_PIXELS-th accepted load: load_color drops next cycle, state goes to SEND. 15 loads for the default; minimum 15 cycles.
- SEND:
  - send_it=1 while in SEND. On a posedge with ready_to_send=1, send_it drops and state goes to WAIT_BUSY, so send_it is high exactly one accepted cycle.
- WAIT_BUSY:
  - Waits for ready_to_load=0 (strand transmitting), then goes to WAIT_DONE.
  - If BUSY_TIMEOUT cycles pass without it, goes to WAIT_DONE anyway.
- WAIT_DONE:
  - Waits for ready_to_load=1, then goes to IDLE with frame_done=1 for one cycle.
- Commit handling:
  - commit while busy=1 sets pending; multiple commits collapse into one.
  - pending is cleared when the next frame starts (IDLE->LOAD).
  - commit in the same cycle as frame_done is treated as pending and starts a frame the cycle after IDLE is entered.
- pixel_index, color_index and color_level are 0 whenever load_color=0.
- Reset asserted mid-frame:
  - Immediate abort; outputs 0 asynchronously.
  - No send_it is issued; pending is dropped.

Test Plan:
- Reset, then write px4 R=FF, px1 B=A0, px2 G=B3, then commit; strand model holds ready_to_load=1 -> 15 consecutive load_color cycles in order (0,00)...(4,10). (4,00)=FF, (1,01)=A0, (2,10)=B3, all others 00. Then send_it for 1 cycle, then frame_done.
- Write px1 color=11 level=D4, and px7 R=11 -> wr_err pulses once per write; the following frame shows all affected entries unchanged.
- Model drops ready_to_load for 3 cycles mid-LOAD at load 6 -> outputs held stable; still exactly 15 accepted loads; pointer not skipped or repeated.
- Commit twice during WAIT_DONE plus a write px0 R=55 during LOAD -> pending=1. Exactly one extra frame follows the first frame_done: the first frame sends R0=00, the second R0=55.
- REFRESH_CYCLES=20, no host activity -> a new frame starts 20 cycles after each frame_done. With REFRESH_CYCLES=0 no frame starts in 1000 cycles.
- Assert reset at load 7 -> all outputs 0 immediately, no send_it; after release, commit sends all-zero data; BUSY_TIMEOUT path exercised by model never dropping ready_to_load.
